alu64_issuer: RTL and testbench

- Initiator/sequencer on the requester side of the 64-bit ALU.
- Accepts tagged ALU commands on a valid/ready request channel and drives the ALU's a/b/op inputs.
- Tracks the ALU's fixed registered latency, captures the ALU result, and returns tagged responses in order on a valid/ready response channel.
- Sits between the instruction/control path and the ALU. Credit-based buffering guarantees no ALU result is ever dropped under response backpressure.

---
 rtl/alu64_pkg.sv | 42 ++++
 rtl/alu64_rsp_fifo.sv | 69 ++++++
 rtl/alu64_issuer.sv | 172 +++++++++++++++++
 tb/tb_alu64_issuer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu64_pkg.sv
// Shared definitions for the 64-bit ALU and its requester-side issuer.
//   ALU_DATA_W  : native ALU operand/result width
//   OP_*        : ALU opcode encodings; OP_IDLE makes the ALU yield zero
//   alu64_rsp_t : default-width view of one response entry {result, tag, err}
//   op_is_reserved() : true for the reserved opcode range 4'hD..4'hF
package alu64_pkg;

  localparam int unsigned ALU_DATA_W = 64;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned ALU_TAG_W  = 4;

  localparam logic [ALU_OP_W-1:0] OP_ADD    = 4'h0;
  localparam logic [ALU_OP_W-1:0] OP_SUB    = 4'h1;
  localparam logic [ALU_OP_W-1:0] OP_MUL    = 4'h2;
  localparam logic [ALU_OP_W-1:0] OP_AND    = 4'h3;
  localparam logic [ALU_OP_W-1:0] OP_OR     = 4'h4;
  localparam logic [ALU_OP_W-1:0] OP_XOR    = 4'h5;
  localparam logic [ALU_OP_W-1:0] OP_NOT    = 4'h6;
  localparam logic [ALU_OP_W-1:0] OP_SHL    = 4'h7;
  localparam logic [ALU_OP_W-1:0] OP_SHR    = 4'h8;
  localparam logic [ALU_OP_W-1:0] OP_ROR2   = 4'h9;
  localparam logic [ALU_OP_W-1:0] OP_ROR3   = 4'hA;
  localparam logic [ALU_OP_W-1:0] OP_ROL2   = 4'hB;
  localparam logic [ALU_OP_W-1:0] OP_ROL3   = 4'hC;
  localparam logic [ALU_OP_W-1:0] OP_RSVD_D = 4'hD;
  localparam logic [ALU_OP_W-1:0] OP_RSVD_E = 4'hE;
  localparam logic [ALU_OP_W-1:0] OP_RSVD_F = 4'hF;

  // Opcode driven whenever nothing is issued; the ALU returns zero for it.
  localparam logic [ALU_OP_W-1:0] OP_IDLE   = 4'hE;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [ALU_TAG_W-1:0]  tag;
    logic                  err;
  } alu64_rsp_t;

  function automatic logic op_is_reserved(input logic [ALU_OP_W-1:0] op);
    return op >= OP_RSVD_D;
  endfunction

endpackage

// File: rtl/alu64_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
//   clk, rst_n   : clock, asynchronous active-low reset (clears pointers, count and storage)
//   push_i/push_data_i : write one entry; accepted when not full or when popping the same cycle
//   pop_i        : consume the head entry; ignored when empty
//   pop_data_o   : head entry (all zeros after reset)
//   empty_o      : no entries held
//   count_o      : number of entries held
// Depth must be a power of two so the pointers wrap naturally.
module alu64_rsp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
  assign do_push = push_i && (!full || do_pop);

  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Credit accounting upstream makes this unreachable.
  overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full && !pop_i));

endmodule

// File: rtl/alu64_issuer.sv
// Requester-side sequencer for the 64-bit ALU.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : tagged command channel (req_op, req_a, req_b, req_tag)
//   alu_a/alu_b/alu_op      : registered drive to the ALU; alu_op idles at OP_IDLE
//   alu_result              : ALU output, valid ALU_LAT edges after the ALU samples its inputs
//   rsp_valid/rsp_ready     : in-order response channel (rsp_result, rsp_tag, rsp_err)
// Every accepted command reserves a response FIFO slot up front, so results leaving the
// in-flight pipe always find room regardless of response backpressure.
// Build option ALU64_ISSUER_OPCHK_EN: reserved opcodes (4'hD..4'hF) are not sent to the ALU
// and come back with rsp_result=0, rsp_err=1. Without it rsp_err is constant 0.
module alu64_issuer
  import alu64_pkg::*;
#(
  parameter int unsigned DATA_W    = ALU_DATA_W,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  // One stage for the ALU input register plus ALU_LAT stages inside the ALU.
  localparam int unsigned PipeN = ALU_LAT + 1;
  localparam int unsigned CntW  = $clog2(RSP_DEPTH + 1);
`ifdef ALU64_ISSUER_OPCHK_EN
  localparam int unsigned EntW  = DATA_W + TAG_W + 1;
`else
  localparam int unsigned EntW  = DATA_W + TAG_W;
`endif

  logic              accept, issue, req_rsvd;
  logic              ready_en_q;
  logic [PipeN-1:0]  pipe_vld_q;
  logic [TAG_W-1:0]  pipe_tag_q [PipeN];
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [3:0]        alu_op_q;
  logic [EntW-1:0]   push_data, head_data;
  logic              push, pop, fifo_empty;
  logic [CntW-1:0]   fifo_cnt;
  int unsigned       credit_used;

  // Credits come from registered state only, so req_ready has no path from
  // req_valid or rsp_ready; a pop frees its slot from the following cycle.
  always_comb begin
    credit_used = 32'(fifo_cnt);
    for (int unsigned i = 0; i < PipeN; i++) begin
      credit_used = credit_used + 32'(pipe_vld_q[i]);
    end
    req_ready = ready_en_q && (credit_used < RSP_DEPTH);
  end

  assign accept = req_valid && req_ready;

`ifdef ALU64_ISSUER_OPCHK_EN
  logic [PipeN-1:0]  pipe_err_q;
  logic [DATA_W-1:0] push_result;

  assign req_rsvd = op_is_reserved(req_op);
`else
  assign req_rsvd = 1'b0;
`endif

  // Reserved commands still consume a slot but never reach the ALU.
  assign issue = accept && !req_rsvd;

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // Operands hold between commands; only the opcode drops back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_IDLE;
    end else begin
      alu_op_q <= issue ? req_op : OP_IDLE;
      if (issue) begin
        alu_a_q <= req_a;
        alu_b_q <= req_b;
      end
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

  // In-flight pipe: stage PipeN-1 lines up with alu_result for the same command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < PipeN; i++) begin
        pipe_tag_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= accept;
      pipe_tag_q[0] <= req_tag;
      for (int unsigned i = 1; i < PipeN; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

`ifdef ALU64_ISSUER_OPCHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_err_q <= '0;
    end else begin
      pipe_err_q[0] <= req_rsvd;
      for (int unsigned i = 1; i < PipeN; i++) begin
        pipe_err_q[i] <= pipe_err_q[i-1];
      end
    end
  end

  assign push_result = pipe_err_q[PipeN-1] ? {DATA_W{1'b0}} : alu_result;
  assign push_data   = {push_result, pipe_tag_q[PipeN-1], pipe_err_q[PipeN-1]};
`else
  assign push_data   = {alu_result, pipe_tag_q[PipeN-1]};
`endif

  assign push = pipe_vld_q[PipeN-1];

  alu64_rsp_fifo #(
    .Width (EntW),
    .Depth (RSP_DEPTH),
    .CntW  (CntW)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (head_data),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;

`ifdef ALU64_ISSUER_OPCHK_EN
  assign {rsp_result, rsp_tag, rsp_err} = head_data;
`else
  assign {rsp_result, rsp_tag} = head_data;
  assign rsp_err               = 1'b0;
`endif

endmodule

// File: tb/tb_alu64_issuer.sv
// Bench for alu64_issuer: a registered ALU stand-in, a queue-based response model checked
// every cycle, and directed vectors with literal expectations.
module tb_alu64_issuer;
  import alu64_pkg::*;

  localparam int unsigned DW    = 64;
  localparam int unsigned TW    = 4;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;
`ifdef ALU64_ISSUER_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [3:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic [TW-1:0] req_tag;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_op;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [TW-1:0] rsp_tag;
  logic          rsp_err;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int unsigned ecnt   = 0;
  bit          live   = 1'b0;

  always #5 clk = ~clk;

  alu64_issuer #(
    .DATA_W    (DW),
    .TAG_W     (TW),
    .ALU_LAT   (LAT),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err)
  );

  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    int unsigned s;
    s = 32'(b[5:0]);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a * b;
      4'h3:    return a & b;
      4'h4:    return a | b;
      4'h5:    return a ^ b;
      4'h6:    return ~a;
      4'h7:    return a << s;
      4'h8:    return a >> s;
      4'h9:    return (a >> s) | (a << (64 - s));
      4'hA:    return (a >> 3) | (a << 61);
      4'hB:    return (a << s) | (a >> (64 - s));
      4'hC:    return (a << 3) | (a >> 61);
      default: return 64'h0;
    endcase
  endfunction

  // Registered ALU with LAT edges of latency.
  logic [DW-1:0] alu_pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(alu_op, alu_a, alu_b);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Model: every accepted command owes one response, due LAT+2 edges after acceptance,
  // delivered strictly in order; outstanding commands may never exceed DEPTH.
  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          err;
    int unsigned   due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] log_res[$];
  logic [TW-1:0] log_tag[$];
  logic          log_err[$];
  logic          pend   = 1'b0;
  logic [3:0]    pend_op = OP_IDLE;
  logic [DW-1:0] last_a = '0, last_b = '0;

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always @(negedge clk) begin : monitor
    bit   exp_valid, rsvd;
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      pend   = 1'b0;
      last_a = '0;
      last_b = '0;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_result", rsp_result, 64'd0);
      chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'(OP_IDLE));
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_alu_b", alu_b, 64'd0);
    end else begin
      exp_valid = 1'b0;
      if (exp_q.size() > 0) exp_valid = (ecnt >= exp_q[0].due);
      chk("req_ready", 64'(req_ready), 64'(live && (exp_q.size() < DEPTH)));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      chk("alu_op", 64'(alu_op), 64'(pend ? pend_op : OP_IDLE));
      chk("alu_a", alu_a, last_a);
      chk("alu_b", alu_b, last_b);
      if (rsp_valid && exp_valid) begin
        chk("rsp_result", rsp_result, exp_q[0].res);
        chk("rsp_tag", 64'(rsp_tag), 64'(exp_q[0].tag));
        chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
        if (rsp_ready) begin
          log_res.push_back(rsp_result);
          log_tag.push_back(rsp_tag);
          log_err.push_back(rsp_err);
          void'(exp_q.pop_front());
        end
      end
      pend = 1'b0;
      if (req_valid && req_ready) begin
        rsvd  = OPCHK && (req_op >= 4'hD);
        e.res = rsvd ? 64'd0 : alu_fn(req_op, req_a, req_b);
        e.tag = req_tag;
        e.err = rsvd;
        e.due = ecnt + LAT + 2;
        exp_q.push_back(e);
        pend    = 1'b1;
        pend_op = rsvd ? OP_IDLE : req_op;
        if (!rsvd) begin
          last_a = req_a;
          last_b = req_b;
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] tag);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    fail_now("send");
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_now(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          base, n, acc;
    bit          hs;
    int unsigned t0, t1, t2;
    logic [4:0]  pat;

    req_valid = 1'b0;
    req_op    = 4'h0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;

    // Reset and release
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ready_at_release", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 chk("ready_after_edge", 64'(req_ready), 64'd1);

    // Basic add and its latency
    base = log_res.size();
    send(4'h0, 64'd5, 64'd7, 4'd3);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
    chk("add_latency", 64'(n), 64'd3);
    wait_idle("add_drain");
    chk("add_result", log_res[base], 64'd12);
    chk("add_tag", 64'(log_tag[base]), 64'd3);
    chk("add_err", 64'(log_err[base]), 64'd0);

    // Subtract wraps
    base = log_res.size();
    send(4'h1, 64'd3, 64'd5, 4'd9);
    wait_idle("sub_drain");
    chk("sub_result", log_res[base], 64'hFFFF_FFFF_FFFF_FFFE);

    // Back-to-back rotate / shift / and
    base = log_res.size();
    send(4'h9, 64'h1, 64'h1, 4'd1);
    t0 = ecnt;
    send(4'h7, 64'h1, 64'h3, 4'd2);
    t1 = ecnt;
    send(4'h3, 64'hF0, 64'h3C, 4'd3);
    t2 = ecnt;
    chk("b2b_gap1", 64'(t1 - t0), 64'd1);
    chk("b2b_gap2", 64'(t2 - t1), 64'd1);
    wait_idle("b2b_drain");
    chk("b2b_ror", log_res[base], 64'h8000_0000_0000_0000);
    chk("b2b_shl", log_res[base+1], 64'h8);
    chk("b2b_and", log_res[base+2], 64'h30);

    // Backpressure: only DEPTH commands fit while responses are stalled
    base      = log_res.size();
    rsp_ready = 1'b0;
    acc       = 0;
    for (int c = 0; c < 12 && acc < 6; c++) begin
      req_op    = 4'h0;
      req_a     = 64'(100 + acc);
      req_b     = 64'(acc);
      req_tag   = 4'(acc);
      req_valid = 1'b1;
      @(negedge clk);
      hs = req_ready;
      @(posedge clk);
      #1;
      if (hs) acc++;
    end
    req_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    for (int j = acc; j < 6; j++) send(4'h0, 64'(100 + j), 64'(j), 4'(j));
    wait_idle("bp_drain");
    chk("bp_count", 64'(log_res.size() - base), 64'd6);
    for (int j = 0; j < 6; j++) begin
      chk("bp_order_tag", 64'(log_tag[base+j]), 64'(j));
      chk("bp_order_res", log_res[base+j], 64'(100 + 2 * j));
    end

    // Streaming with intermittent backpressure and duplicate tags
    base = log_res.size();
    pat  = 5'b10110;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(4'(i + 2), {32'hDEAD_BEEF, 32'(i)}, 64'(i * 7 + 1), 4'(i % 3));
        end
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(posedge clk);
          #1 rsp_ready = pat[c % 5];
        end
      end
    join
    rsp_ready = 1'b1;
    wait_idle("stream_drain");
    chk("stream_count", 64'(log_res.size() - base), 64'd8);

    // Reset with two in flight and one buffered
    rsp_ready = 1'b0;
    send(4'h4, 64'hF0, 64'h0F, 4'd1);
    send(4'h4, 64'h1, 64'h2, 4'd2);
    send(4'h4, 64'h4, 64'h8, 4'd3);
    chk("rst_pre_buffered", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_now_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_now_req_ready", 64'(req_ready), 64'd0);
    chk("rst_now_rsp_result", rsp_result, 64'd0);
    chk("rst_now_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_now_alu_op", 64'(alu_op), 64'hE);
    chk("rst_now_alu_a", alu_a, 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("rst_no_stale", 64'(n), 64'd0);
    @(posedge clk);
    #1;

    // Reserved opcode
    base = log_res.size();
    send(4'hD, 64'd11, 64'd22, 4'd7);
    chk("rsvd_alu_op", 64'(alu_op), OPCHK ? 64'hE : 64'hD);
    wait_idle("rsvd_drain");
    chk("rsvd_result", log_res[base], 64'd0);
    chk("rsvd_tag", 64'(log_tag[base]), 64'd7);
    chk("rsvd_err", 64'(log_err[base]), 64'(OPCHK));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
